// File: rtl/linebuff_mem.sv
// Line-buffer word store: one write port, one registered read port, hardware clear
// sequence after reset/frame start, write-first forwarding and out-of-range protection.
module linebuff_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TAP_NUMS   = 3,
  parameter int LINE_DEPTH = 1920,
  parameter int INIT_CLEAR = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr_i,
  input  logic                                 rd_ce_i,
  input  logic [ADDR_WIDTH-1:0]                rd_addr_i,
  output logic [(TAP_NUMS-1)*DATA_WIDTH-1:0]   rd_data_o,
  input  logic                                 wr_en_i,
  input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
  input  logic [(TAP_NUMS-1)*DATA_WIDTH-1:0]   wr_data_i,
  output logic                                 init_busy_o,
  output logic                                 addr_err_o,
  input  logic                                 err_clr_i
);

  localparam int W  = (TAP_NUMS - 1) * DATA_WIDTH;
  localparam int IW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(LINE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(LINE_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [IW-1:0]   clr_cnt;
  logic [W-1:0]    mem [0:LINE_DEPTH-1];

  logic            wr_in_range;
  logic            rd_in_range;
  logic            mem_we;
  logic [IW-1:0]   mem_waddr;
  logic [W-1:0]    mem_wdata;

  // Range checks use the full bus so wrapped controller addresses never alias a word.
  assign wr_in_range = (wr_addr_i < DEPTH_A);
  assign rd_in_range = (rd_addr_i < DEPTH_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
      init_busy_o <= (INIT_CLEAR != 0);
      clr_cnt     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (clr_i) begin
            clr_cnt <= '0;
          end else if (clr_cnt == LAST_IDX) begin
            state       <= S_RUN;
            init_busy_o <= 1'b0;
            clr_cnt     <= '0;
          end else begin
            clr_cnt <= clr_cnt + IW'(1);
          end
        end
        default: begin
          if (clr_i) begin
            state       <= S_INIT;
            init_busy_o <= 1'b1;
            clr_cnt     <= '0;
          end
        end
      endcase
    end
  end

  // The clear sequence owns the single write port while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i[IW-1:0];
    mem_wdata = wr_data_i;
    if (state == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (wr_en_i && wr_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else if (rd_ce_i) begin
      if ((state == S_INIT) || !rd_in_range) begin
        rd_data_o <= '0;
      end else if (wr_en_i && wr_in_range && (wr_addr_i == rd_addr_i)) begin
        rd_data_o <= wr_data_i;
      end else begin
        rd_data_o <= mem[rd_addr_i[IW-1:0]];
      end
    end
  end

  // Setting wins over a same-cycle clear so no error event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_o <= 1'b0;
    end else if ((state == S_RUN) &&
                 ((wr_en_i && !wr_in_range) || (rd_ce_i && !rd_in_range))) begin
      addr_err_o <= 1'b1;
    end else if (err_clr_i) begin
      addr_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_linebuff_mem.sv
// Directed bench for linebuff_mem with a word-array reference model checked every cycle.
module tb_linebuff_mem;

  localparam int LD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_i = 1'b0;
  logic        rd_ce_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic [15:0] rd_data_o;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_addr_i = '0;
  logic [15:0] wr_data_i = '0;
  logic        init_busy_o;
  logic        addr_err_o;
  logic        err_clr_i = 1'b0;

  int          checkCount = 0;
  int          errorCount = 0;
  logic        cmpEnable = 1'b0;

  logic [15:0] modelMem [LD];
  logic [15:0] modelRd = '0;
  logic        modelErr = 1'b0;
  int          busyLeft = LD;

  linebuff_mem #(
    .DATA_WIDTH(8), .ADDR_WIDTH(32), .TAP_NUMS(3), .LINE_DEPTH(LD), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .rd_ce_i(rd_ce_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .init_busy_o(init_busy_o), .addr_err_o(addr_err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: clear walks words 0..LD-1 one per cycle; accesses use write-then-read order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyLeft = LD;
      modelRd  = '0;
      modelErr = 1'b0;
    end else if (busyLeft > 0) begin
      modelMem[LD - busyLeft] = '0;
      if (rd_ce_i) modelRd = '0;
      if (err_clr_i) modelErr = 1'b0;
      busyLeft = clr_i ? LD : busyLeft - 1;
    end else begin
      if (wr_en_i && wr_addr_i < LD) modelMem[int'(wr_addr_i)] = wr_data_i;
      if (rd_ce_i) modelRd = (rd_addr_i < LD) ? modelMem[int'(rd_addr_i)] : 16'h0;
      if ((wr_en_i && wr_addr_i >= LD) || (rd_ce_i && rd_addr_i >= LD)) modelErr = 1'b1;
      else if (err_clr_i) modelErr = 1'b0;
      if (clr_i) busyLeft = LD;
    end
  end

  always @(negedge clk) begin
    if (cmpEnable) begin
      checkOutput("model_rd_data", 32'(rd_data_o), 32'(modelRd));
      checkOutput("model_busy", 32'(init_busy_o), 32'(busyLeft > 0));
      checkOutput("model_err", 32'(addr_err_o), 32'(modelErr));
    end
  end

  task automatic applyStimulus(input logic rdCe, input logic [31:0] rdAddr,
                               input logic wrEn, input logic [31:0] wrAddr,
                               input logic [15:0] wrData, input logic clr,
                               input logic errClr);
    rd_ce_i = rdCe; rd_addr_i = rdAddr;
    wr_en_i = wrEn; wr_addr_i = wrAddr; wr_data_i = wrData;
    clr_i = clr; err_clr_i = errClr;
    @(posedge clk);
    #1;
    rd_ce_i = 1'b0; wr_en_i = 1'b0; clr_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [15:0] data);
    applyStimulus(1'b0, 32'h0, 1'b1, addr, data, 1'b0, 1'b0);
  endtask

  task automatic doRead(input logic [31:0] addr);
    applyStimulus(1'b1, addr, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic countBusy(input int restartAt, output int cycles);
    cycles = 0;
    while (init_busy_o && cycles < 100) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 32'(cycles % LD), 16'hDEAD,
                    (cycles == restartAt), 1'b0);
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    #12;
    rst_n = 1'b1;
    cmpEnable = 1'b1;
    checkOutput("reset_busy", 32'(init_busy_o), 32'h1);
    checkOutput("reset_rd", 32'(rd_data_o), 32'h0);

    // Power-up clear lasts exactly LD cycles and leaves every word zero.
    countBusy(-1, cycles);
    checkOutput("init_cycles", 32'(cycles), 32'd16);
    for (int i = 0; i < LD; i++) begin
      doRead(32'(i));
      checkOutput("init_word_zero", 32'(rd_data_o), 32'h0);
    end

    doWrite(32'd5, 16'hA55A);
    idle();
    doRead(32'd5);
    checkOutput("read_a55a", 32'(rd_data_o), 32'hA55A);
    idle(); idle();
    checkOutput("hold_a55a", 32'(rd_data_o), 32'hA55A);

    doWrite(32'd7, 16'hFFFF);
    applyStimulus(1'b1, 32'd7, 1'b1, 32'd7, 16'h1234, 1'b0, 1'b0);
    checkOutput("write_first", 32'(rd_data_o), 32'h1234);
    doRead(32'd7);
    checkOutput("after_forward", 32'(rd_data_o), 32'h1234);

    doWrite(32'd14, 16'h1414);
    doWrite(32'd15, 16'h1515);
    checkOutput("err_clean", 32'(addr_err_o), 32'h0);
    doWrite(32'hFFFF_FFFE, 16'hBEEF);
    checkOutput("err_set_wr", 32'(addr_err_o), 32'h1);
    doRead(32'd14);
    checkOutput("word14_kept", 32'(rd_data_o), 32'h1414);
    doRead(32'd15);
    checkOutput("word15_kept", 32'(rd_data_o), 32'h1515);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("err_cleared", 32'(addr_err_o), 32'h0);
    doRead(32'd16);
    checkOutput("oor_read_zero", 32'(rd_data_o), 32'h0);
    checkOutput("err_set_rd", 32'(addr_err_o), 32'h1);
    applyStimulus(1'b1, 32'd20, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("err_set_wins", 32'(addr_err_o), 32'h1);

    // Frame-start clear over a full buffer; writes during the clear must be ignored.
    for (int i = 0; i < LD; i++) doWrite(32'(i), 16'h00FF);
    applyStimulus(1'b1, 32'd3, 1'b1, 32'd9, 16'h00FF, 1'b1, 1'b0);
    checkOutput("clr_access_done", 32'(rd_data_o), 32'h00FF);
    checkOutput("clr_busy", 32'(init_busy_o), 32'h1);
    countBusy(-1, cycles);
    checkOutput("clr_cycles", 32'(cycles), 32'd16);
    for (int i = 0; i < LD; i++) begin
      doRead(32'(i));
      checkOutput("clr_word_zero", 32'(rd_data_o), 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    countBusy(7, cycles);
    checkOutput("restart_cycles", 32'(cycles), 32'd24);

    doWrite(32'd2, 16'h5A5A);
    doWrite(32'h20, 16'h0);
    doRead(32'd2);
    checkOutput("pre_reset_rd", 32'(rd_data_o), 32'h5A5A);
    checkOutput("pre_reset_err", 32'(addr_err_o), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rd", 32'(rd_data_o), 32'h0);
    checkOutput("async_rst_err", 32'(addr_err_o), 32'h0);
    checkOutput("async_rst_busy", 32'(init_busy_o), 32'h1);
    #2;
    rst_n = 1'b1;
    countBusy(-1, cycles);
    checkOutput("rst_init_cycles", 32'(cycles), 32'd16);
    doRead(32'd2);
    checkOutput("rst_word_zero", 32'(rd_data_o), 32'h0);

    idle();
    cmpEnable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
